// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake,
// and feeds IF/ID with a word (or a zero bubble) plus flush on redirects.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h80000000,
   parameter logic [31:0] EXC_PC   = 32'h80000004
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_PC,
   output logic [31:0] instruction,
   output logic        IFID_flush,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      FETCH,
      HAVE,
      DROP
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_buf;
   logic [31:0] drop_addr;
   logic        redir;
   logic [31:0] tgt;
   logic [31:0] pc_next_seq;

   // Exceptions take precedence over branch/jump redirects.
   assign redir       = exc | redirect;
   assign tgt         = exc ? EXC_PC : redirect_pc;
   assign pc_next_seq = pc + 32'd4;

   // While draining an abandoned request the old address must stay on the bus.
   always_comb begin
      imem_req    = (state == FETCH) || (state == DROP);
      imem_addr   = (state == DROP) ? drop_addr : pc;
      IF_PC       = pc;
      IFID_flush  = redir;
      instruction = 32'd0;
      fetch_busy  = 1'b1;
      if (state == FETCH && imem_ack) begin
         instruction = imem_rdata;
         fetch_busy  = 1'b0;
      end else if (state == HAVE) begin
         instruction = hold_buf;
         fetch_busy  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         hold_buf  <= 32'd0;
         drop_addr <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (redir && imem_ack) begin
                  pc <= tgt;
               end else if (redir) begin
                  drop_addr <= pc;
                  pc        <= tgt;
                  state     <= DROP;
               end else if (imem_ack && !stall) begin
                  pc <= pc_next_seq;
               end else if (imem_ack) begin
                  hold_buf <= imem_rdata;
                  state    <= HAVE;
               end
            end
            HAVE: begin
               if (redir) begin
                  pc    <= tgt;
                  state <= FETCH;
               end else if (!stall) begin
                  pc    <= pc_next_seq;
                  state <= FETCH;
               end
            end
            DROP: begin
               // Late redirects only retarget pc; the stale ack still has to drain.
               if (redir) begin
                  pc <= tgt;
               end
               if (imem_ack) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit; the bench plays the
// instruction memory by driving ack/rdata from each vector.
module tb_if_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_PC;
   logic [31:0] instruction;
   logic        IFID_flush;
   logic        fetch_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        exc;
      logic        ack;
      logic [31:0] rdata;
      logic        chk_addr;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_flush;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   if_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .exc         (exc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .IF_PC       (IF_PC),
      .instruction (instruction),
      .IFID_flush  (IFID_flush),
      .fetch_busy  (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      stall       = v.stall;
      redirect    = v.redirect;
      redirect_pc = v.rpc;
      exc         = v.exc;
      imem_ack    = v.ack;
      imem_rdata  = v.rdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkVec(input int idx, input vec_t v);
      checkOutput($sformatf("v%0d.req", idx), {31'd0, imem_req}, {31'd0, v.e_req});
      if (v.chk_addr)
         checkOutput($sformatf("v%0d.addr", idx), imem_addr, v.e_addr);
      checkOutput($sformatf("v%0d.pc", idx), IF_PC, v.e_pc);
      checkOutput($sformatf("v%0d.instr", idx), instruction, v.e_instr);
      checkOutput($sformatf("v%0d.flush", idx), {31'd0, IFID_flush}, {31'd0, v.e_flush});
      checkOutput($sformatf("v%0d.busy", idx), {31'd0, fetch_busy}, {31'd0, v.e_busy});
   endtask

   initial begin
      // stall, redirect, rpc, exc, ack, rdata, chk_addr, req, addr, pc, instr, flush, busy
      // zero-wait memory, four sequential words
      vq.push_back('{0,0,32'h0,0,1,32'h11111111,1,1,32'h80000000,32'h80000000,32'h11111111,0,0});
      vq.push_back('{0,0,32'h0,0,1,32'h22222222,1,1,32'h80000004,32'h80000004,32'h22222222,0,0});
      vq.push_back('{0,0,32'h0,0,1,32'h33333333,1,1,32'h80000008,32'h80000008,32'h33333333,0,0});
      vq.push_back('{0,0,32'h0,0,1,32'h44444444,1,1,32'h8000000C,32'h8000000C,32'h44444444,0,0});
      // two-cycle memory: bubble then word, address held
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h80000010,32'h80000010,32'h0,0,1});
      vq.push_back('{0,0,32'h0,0,1,32'h55555555,1,1,32'h80000010,32'h80000010,32'h55555555,0,0});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h80000014,32'h80000014,32'h0,0,1});
      vq.push_back('{0,0,32'h0,0,1,32'h66666666,1,1,32'h80000014,32'h80000014,32'h66666666,0,0});
      // ack under stall -> HAVE, buffered word replayed without a request
      vq.push_back('{1,0,32'h0,0,1,32'h77777777,1,1,32'h80000018,32'h80000018,32'h77777777,0,0});
      vq.push_back('{1,0,32'h0,0,0,32'hDEADBEEF,0,0,32'h0,32'h80000018,32'h77777777,0,0});
      vq.push_back('{1,0,32'h0,0,0,32'hDEADBEEF,0,0,32'h0,32'h80000018,32'h77777777,0,0});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,0,0,32'h0,32'h80000018,32'h77777777,0,0});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h8000001C,32'h8000001C,32'h0,0,1});
      // redirect with request pending -> DROP keeps old address until ack
      vq.push_back('{0,1,32'h80000100,0,0,32'hDEADBEEF,1,1,32'h8000001C,32'h8000001C,32'h0,1,1});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h8000001C,32'h80000100,32'h0,0,1});
      vq.push_back('{0,0,32'h0,0,1,32'hBAADF00D,1,1,32'h8000001C,32'h80000100,32'h0,0,1});
      vq.push_back('{0,0,32'h0,0,1,32'h88888888,1,1,32'h80000100,32'h80000100,32'h88888888,0,0});
      // exc + redirect + stall together -> EXC_PC
      vq.push_back('{1,1,32'h80000200,1,1,32'h99999999,1,1,32'h80000104,32'h80000104,32'h99999999,1,0});
      vq.push_back('{0,0,32'h0,0,1,32'hAAAAAAAA,1,1,32'h80000004,32'h80000004,32'hAAAAAAAA,0,0});
      // redirect with ack to top of address space, then wrap to 0
      vq.push_back('{0,1,32'hFFFFFFFC,0,1,32'hBBBBBBBB,1,1,32'h80000008,32'h80000008,32'hBBBBBBBB,1,0});
      vq.push_back('{0,0,32'h0,0,1,32'hCCCCCCCC,1,1,32'hFFFFFFFC,32'hFFFFFFFC,32'hCCCCCCCC,0,0});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h00000000,32'h00000000,32'h0,0,1});
      // redirect out of HAVE while stalled, unaligned target passes through
      vq.push_back('{1,0,32'h0,0,1,32'hDDDDDDDD,1,1,32'h00000000,32'h00000000,32'hDDDDDDDD,0,0});
      vq.push_back('{1,1,32'h80000303,0,0,32'hDEADBEEF,0,0,32'h0,32'h00000000,32'hDDDDDDDD,1,0});
      vq.push_back('{0,0,32'h0,0,0,32'hDEADBEEF,1,1,32'h80000303,32'h80000303,32'h0,0,1});
      // second redirect while in DROP retargets pc but not drop address
      vq.push_back('{0,1,32'h80000400,0,0,32'hDEADBEEF,1,1,32'h80000303,32'h80000303,32'h0,1,1});
      vq.push_back('{0,1,32'h80000500,0,0,32'hDEADBEEF,1,1,32'h80000303,32'h80000400,32'h0,1,1});
      vq.push_back('{0,0,32'h0,0,0,32'hBAADF00D,1,1,32'h80000303,32'h80000500,32'h0,0,1});

      // reset state, including combinational flush during reset
      reset = 1'b1;
      applyStimulus('{0,1,32'h12345678,0,0,32'h0,0,0,32'h0,32'h0,32'h0,0,0});
      #2;
      checkOutput("rst.req", {31'd0, imem_req}, 32'd1);
      checkOutput("rst.addr", imem_addr, 32'h80000000);
      checkOutput("rst.pc", IF_PC, 32'h80000000);
      checkOutput("rst.instr", instruction, 32'h0);
      checkOutput("rst.busy", {31'd0, fetch_busy}, 32'd1);
      checkOutput("rst.flush", {31'd0, IFID_flush}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         applyStimulus(vq[i]);
         #2;
         checkVec(i, vq[i]);
         @(negedge clk);
      end

      // still in DROP; assert reset between clock edges
      applyStimulus('{0,0,32'h0,0,0,32'hBAADF00D,0,0,32'h0,32'h0,32'h0,0,0});
      #2;
      checkOutput("drop.addr", imem_addr, 32'h80000303);
      reset = 1'b1;
      #1;
      checkOutput("arst.req", {31'd0, imem_req}, 32'd1);
      checkOutput("arst.addr", imem_addr, 32'h80000000);
      checkOutput("arst.pc", IF_PC, 32'h80000000);
      checkOutput("arst.instr", instruction, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus('{0,0,32'h0,0,1,32'h12340000,0,0,32'h0,32'h0,32'h0,0,0});
      #2;
      checkOutput("post.addr", imem_addr, 32'h80000000);
      checkOutput("post.instr", instruction, 32'h12340000);
      @(negedge clk);
      applyStimulus('{0,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,32'h0,0,0});
      #2;
      checkOutput("post.pc", IF_PC, 32'h80000004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
